// File: rtl/proto_path_lookup.sv
// rtl/proto_path_lookup.sv - runtime-programmable protobuf message-path resolver
//
// Tracks the embedded-message path of the decoder as a stack of field
// identifiers and resolves (current path, field id) to a node index plus the
// metadata of the matching field. The dependency (path) table and node (field
// metadata) table are registers loaded over the cfg_* port.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cfg_dep_we/idx/data            write one dependency entry (sets its valid bit)
//   cfg_node_we/idx/data           write one node entry (slot 0 in the LSBs)
//   cmd_valid/ready/op/id          command: 00 PUSH, 01 POP, 10 LOOKUP, 11 CLEAR
//   rsp_valid/ready                LOOKUP result handshake
//   rsp_hit/err/node_idx/meta      LOOKUP result (err: 00 OK, 01 NO_NODE, 10 NO_FIELD, 11 BAD_ID)
//   err_o, err_code                stack fault pulse and sticky code (01 OVERFLOW, 10 UNDERFLOW, 11 BAD_ID)
//   path_depth                     current stack depth
//
// Metadata layout: {repeated, required, byte_offset[7:0], embedded, data_type[2:0], identifier}

module proto_path_lookup #(
  parameter int NUM_MSG_HIERARCHY  = 3,
  parameter int NUM_MSGS           = 3,
  parameter int MAX_FIELDS_PER_MSG = 4,
  parameter int IDENTIFIER_SIZE    = 4,
  localparam int META_W  = IDENTIFIER_SIZE + 14,
  localparam int IDX_W   = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
  localparam int DEP_W   = NUM_MSG_HIERARCHY * IDENTIFIER_SIZE,
  localparam int DEPTH_W = $clog2(NUM_MSG_HIERARCHY + 1),
  localparam int NODE_W  = MAX_FIELDS_PER_MSG * META_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_dep_we,
  input  logic [IDX_W-1:0]           cfg_dep_idx,
  input  logic [DEP_W-1:0]           cfg_dep_data,
  input  logic                       cfg_node_we,
  input  logic [IDX_W-1:0]           cfg_node_idx,
  input  logic [NODE_W-1:0]          cfg_node_data,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [IDENTIFIER_SIZE-1:0] cmd_id,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_hit,
  output logic [1:0]                 rsp_err,
  output logic [IDX_W-1:0]           rsp_node_idx,
  output logic [META_W-1:0]          rsp_meta,
  output logic                       err_o,
  output logic [1:0]                 err_code,
  output logic [DEPTH_W-1:0]         path_depth
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FIELD = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_PUSH   = 2'b00;
  localparam logic [1:0] OP_POP    = 2'b01;
  localparam logic [1:0] OP_LOOKUP = 2'b10;

  localparam logic [1:0] RSP_OK       = 2'b00;
  localparam logic [1:0] RSP_NO_NODE  = 2'b01;
  localparam logic [1:0] RSP_NO_FIELD = 2'b10;
  localparam logic [1:0] RSP_BAD_ID   = 2'b11;

  localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
  localparam logic [1:0] ERR_BAD_ID    = 2'b11;

  state_t state_q, state_nxt;

  logic [DEP_W-1:0]           dep_tab  [NUM_MSGS];
  logic [NUM_MSGS-1:0]        dep_valid;
  logic [NODE_W-1:0]          node_tab [NUM_MSGS];
  logic [DEP_W-1:0]           path_q;
  logic [DEPTH_W-1:0]         depth_q;
  logic [IDX_W-1:0]           scan_idx;
  logic [IDX_W-1:0]           match_idx;
  logic [IDENTIFIER_SIZE-1:0] id_q;

  logic                       cmd_fire;
  logic [DEP_W-1:0]           scan_dep;
  logic                       scan_vld;
  logic                       scan_hit;
  logic                       last_entry;
  logic [NODE_W-1:0]          node_row;
  logic                       field_hit;
  logic [META_W-1:0]          field_meta;

  // cmd_ready is registered so that it reads 0 while reset is applied; it
  // follows the next state, so it is high exactly while the FSM sits in IDLE.
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign path_depth = depth_q;

  // Dependency entry under scan (loop mux keeps the index in range).
  always_comb begin
    scan_dep = '0;
    scan_vld = 1'b0;
    for (int k = 0; k < NUM_MSGS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        scan_dep = dep_tab[k];
        scan_vld = dep_valid[k];
      end
    end
  end

  assign scan_hit   = scan_vld && (scan_dep == path_q);
  assign last_entry = (scan_idx == IDX_W'(NUM_MSGS - 1));

  // Field match on the selected node. Walking slots from the top down lets
  // the lowest matching slot overwrite the others. Empty slots carry id 0 and
  // never match because a zero id never reaches FIELD.
  always_comb begin
    node_row   = '0;
    field_hit  = 1'b0;
    field_meta = '0;
    for (int k = 0; k < NUM_MSGS; k++) begin
      if (match_idx == IDX_W'(k)) node_row = node_tab[k];
    end
    for (int s = MAX_FIELDS_PER_MSG - 1; s >= 0; s--) begin
      if (node_row[s*META_W +: IDENTIFIER_SIZE] == id_q) begin
        field_hit  = 1'b1;
        field_meta = node_row[s*META_W +: META_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire && cmd_op == OP_LOOKUP) begin
          state_nxt = (cmd_id == '0) ? S_RESP : S_SCAN;
        end
      end
      S_SCAN: begin
        if (scan_hit)        state_nxt = S_FIELD;
        else if (last_entry) state_nxt = S_RESP;
      end
      S_FIELD: state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_hit      <= 1'b0;
      rsp_err      <= '0;
      rsp_node_idx <= '0;
      rsp_meta     <= '0;
      err_o        <= 1'b0;
      err_code     <= '0;
      path_q       <= '0;
      depth_q      <= '0;
      scan_idx     <= '0;
      match_idx    <= '0;
      id_q         <= '0;
      dep_valid    <= '0;
      for (int k = 0; k < NUM_MSGS; k++) begin
        dep_tab[k]  <= '0;
        node_tab[k] <= '0;
      end
    end else begin
      err_o     <= 1'b0;
      cmd_ready <= (state_nxt == S_IDLE);

      // Configuration writes; out-of-range indices are dropped.
      for (int k = 0; k < NUM_MSGS; k++) begin
        if (cfg_dep_we && cfg_dep_idx == IDX_W'(k)) begin
          dep_tab[k]   <= cfg_dep_data;
          dep_valid[k] <= 1'b1;
        end
        if (cfg_node_we && cfg_node_idx == IDX_W'(k)) begin
          node_tab[k] <= cfg_node_data;
        end
      end

      if (cmd_fire) begin
        case (cmd_op)
          OP_PUSH: begin
            if (cmd_id == '0) begin
              err_o    <= 1'b1;
              err_code <= ERR_BAD_ID;
            end else if (depth_q >= DEPTH_W'(NUM_MSG_HIERARCHY)) begin
              err_o    <= 1'b1;
              err_code <= ERR_OVERFLOW;
            end else begin
              for (int l = 0; l < NUM_MSG_HIERARCHY; l++) begin
                if (depth_q == DEPTH_W'(l)) path_q[l*IDENTIFIER_SIZE +: IDENTIFIER_SIZE] <= cmd_id;
              end
              depth_q <= depth_q + 1'b1;
            end
          end
          OP_POP: begin
            if (depth_q == '0) begin
              err_o    <= 1'b1;
              err_code <= ERR_UNDERFLOW;
            end else begin
              // Popped level is zeroed so the path keeps comparing against
              // tables whose unused levels are zero.
              for (int l = 0; l < NUM_MSG_HIERARCHY; l++) begin
                if (depth_q == DEPTH_W'(l + 1)) path_q[l*IDENTIFIER_SIZE +: IDENTIFIER_SIZE] <= '0;
              end
              depth_q <= depth_q - 1'b1;
            end
          end
          OP_LOOKUP: begin
            id_q     <= cmd_id;
            scan_idx <= '0;
            if (cmd_id == '0) begin
              rsp_valid    <= 1'b1;
              rsp_hit      <= 1'b0;
              rsp_err      <= RSP_BAD_ID;
              rsp_node_idx <= '0;
              rsp_meta     <= '0;
            end
          end
          default: begin
            path_q  <= '0;
            depth_q <= '0;
          end
        endcase
      end

      case (state_q)
        S_SCAN: begin
          if (scan_hit) begin
            match_idx <= scan_idx;
          end else if (last_entry) begin
            rsp_valid    <= 1'b1;
            rsp_hit      <= 1'b0;
            rsp_err      <= RSP_NO_NODE;
            rsp_node_idx <= '0;
            rsp_meta     <= '0;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        S_FIELD: begin
          rsp_valid    <= 1'b1;
          rsp_hit      <= field_hit;
          rsp_err      <= field_hit ? RSP_OK : RSP_NO_FIELD;
          rsp_node_idx <= match_idx;
          rsp_meta     <= field_hit ? field_meta : '0;
        end
        S_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proto_path_lookup.sv
// tb/tb_proto_path_lookup.sv - self-checking bench for proto_path_lookup

module tb_proto_path_lookup;

  localparam logic [3:0] A = 4'h5;
  localparam logic [3:0] B = 4'h6;
  localparam logic [3:0] C = 4'h7;

  localparam logic [17:0] M_N0S0 = 18'h0A083;
  localparam logic [17:0] M_N1S0 = 18'h21084;
  localparam logic [17:0] M_N1S1 = 18'h12345;
  localparam logic [17:0] M_N1S2 = 18'h3F004;
  localparam logic [17:0] M_N2S0 = 18'h10041;
  localparam logic [17:0] M_N2S1 = 18'h08C22;

  localparam logic [1:0] OP_PUSH = 2'b00, OP_POP = 2'b01, OP_LOOKUP = 2'b10, OP_CLEAR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_dep_we = 1'b0;
  logic [1:0]  cfg_dep_idx = '0;
  logic [11:0] cfg_dep_data = '0;
  logic        cfg_node_we = 1'b0;
  logic [1:0]  cfg_node_idx = '0;
  logic [71:0] cfg_node_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_id = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_hit;
  logic [1:0]  rsp_err;
  logic [1:0]  rsp_node_idx;
  logic [17:0] rsp_meta;
  logic        err_o;
  logic [1:0]  err_code;
  logic [1:0]  path_depth;

  proto_path_lookup dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_dep_we(cfg_dep_we), .cfg_dep_idx(cfg_dep_idx), .cfg_dep_data(cfg_dep_data),
    .cfg_node_we(cfg_node_we), .cfg_node_idx(cfg_node_idx), .cfg_node_data(cfg_node_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_id(cmd_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .rsp_node_idx(rsp_node_idx), .rsp_meta(rsp_meta),
    .err_o(err_o), .err_code(err_code), .path_depth(path_depth)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          np;
    logic [3:0]  p0, p1, p2;
    logic [3:0]  id;
    int          lat;
    logic        hit;
    logic [1:0]  err;
    logic [1:0]  idx;
    logic [17:0] meta;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int fire_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input int np, input logic [3:0] p0, input logic [3:0] p1,
                         input logic [3:0] p2, input logic [3:0] id, input int lat, input logic hit,
                         input logic [1:0] err, input logic [1:0] idx, input logic [17:0] meta);
    vec_t v;
    v.name = nm; v.np = np; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.id = id;
    v.lat = lat; v.hit = hit; v.err = err; v.idx = idx; v.meta = meta;
    vecs.push_back(v);
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] id);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_id = id;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    fire_cyc  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic set_path(input int np, input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2);
    issue(OP_CLEAR, 4'h0);
    if (np > 0) issue(OP_PUSH, p0);
    if (np > 1) issue(OP_PUSH, p1);
    if (np > 2) issue(OP_PUSH, p2);
  endtask

  task automatic lookup(input vec_t v);
    sb.push_back(v);
    issue(OP_LOOKUP, v.id);
  endtask

  task automatic collect();
    vec_t e;
    int w;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    w = 0;
    @(negedge clk);
    while (!rsp_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({e.name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    if (!rsp_valid) return;
    check({e.name, "_latency"}, cyc - fire_cyc + 1, e.lat);
    check({e.name, "_hit"}, {31'd0, rsp_hit}, {31'd0, e.hit});
    check({e.name, "_err"}, {30'd0, rsp_err}, {30'd0, e.err});
    check({e.name, "_node_idx"}, {30'd0, rsp_node_idx}, {30'd0, e.idx});
    check({e.name, "_meta"}, {14'd0, rsp_meta}, {14'd0, e.meta});
    if (rsp_ready) begin
      @(posedge clk);
      #1;
      check({e.name, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  task automatic cfg_dep(input logic [1:0] idx, input logic [11:0] data);
    @(negedge clk);
    cfg_dep_we = 1'b1; cfg_dep_idx = idx; cfg_dep_data = data;
    @(negedge clk);
    cfg_dep_we = 1'b0;
  endtask

  task automatic cfg_node(input logic [1:0] idx, input logic [71:0] data);
    @(negedge clk);
    cfg_node_we = 1'b1; cfg_node_idx = idx; cfg_node_data = data;
    @(negedge clk);
    cfg_node_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit seen;

    add_vec("hit_AB",      2, A, B, 0, 4'h4, 4, 1'b1, 2'b00, 2'd1, M_N1S0);
    add_vec("slot1_AB",    2, A, B, 0, 4'h5, 4, 1'b1, 2'b00, 2'd1, M_N1S1);
    add_vec("nonode_d0",   0, 0, 0, 0, 4'h1, 4, 1'b0, 2'b01, 2'd0, 18'h0);
    add_vec("nofield_ABC", 3, A, B, C, 4'h3, 5, 1'b0, 2'b10, 2'd2, 18'h0);
    add_vec("hit_ABC",     3, A, B, C, 4'h2, 5, 1'b1, 2'b00, 2'd2, M_N2S1);
    add_vec("hit_ABC_s0",  3, A, B, C, 4'h1, 5, 1'b1, 2'b00, 2'd2, M_N2S0);
    add_vec("hit_A",       1, A, 0, 0, 4'h3, 3, 1'b1, 2'b00, 2'd0, M_N0S0);
    add_vec("nofield_A",   1, A, 0, 0, 4'h4, 3, 1'b0, 2'b10, 2'd0, 18'h0);
    add_vec("nonode_B",    1, B, 0, 0, 4'h4, 4, 1'b0, 2'b01, 2'd0, 18'h0);
    add_vec("badid",       1, A, 0, 0, 4'h0, 1, 1'b0, 2'b11, 2'd0, 18'h0);

    #3;
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_err_o", {31'd0, err_o}, 32'd0);
    check("reset_err_code", {30'd0, err_code}, 32'd0);
    check("reset_depth", {30'd0, path_depth}, 32'd0);
    check("reset_meta", {14'd0, rsp_meta}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    cfg_dep(2'd0, {4'h0, 4'h0, A});
    cfg_dep(2'd1, {4'h0, B, A});
    cfg_dep(2'd2, {C, B, A});
    cfg_node(2'd0, {18'h0, 18'h0, 18'h0, M_N0S0});
    cfg_node(2'd1, {18'h0, M_N1S2, M_N1S1, M_N1S0});
    cfg_node(2'd2, {18'h0, 18'h0, M_N2S1, M_N2S0});

    foreach (vecs[i]) begin
      v = vecs[i];
      set_path(v.np, v.p0, v.p1, v.p2);
      lookup(v);
      collect();
    end

    // Overflow: fourth push at full depth.
    set_path(3, A, B, C);
    issue(OP_PUSH, 4'h1);
    check("ovf_err_o", {31'd0, err_o}, 32'd1);
    check("ovf_err_code", {30'd0, err_code}, 32'd1);
    check("ovf_depth", {30'd0, path_depth}, 32'd3);
    @(posedge clk); #1;
    check("ovf_err_o_pulse", {31'd0, err_o}, 32'd0);
    check("ovf_code_held", {30'd0, err_code}, 32'd1);

    // Pop then lookup: popped level must be cleared so {A,B} matches node 1.
    issue(OP_POP, 4'h0);
    check("pop_depth", {30'd0, path_depth}, 32'd2);
    check("pop_no_err", {31'd0, err_o}, 32'd0);
    v = vecs[0]; v.name = "after_pop";
    lookup(v);
    collect();

    // Underflow.
    issue(OP_CLEAR, 4'h0);
    check("clear_depth", {30'd0, path_depth}, 32'd0);
    issue(OP_POP, 4'h0);
    check("unf_err_o", {31'd0, err_o}, 32'd1);
    check("unf_err_code", {30'd0, err_code}, 32'd2);
    check("unf_depth", {30'd0, path_depth}, 32'd0);

    // Push of id 0.
    issue(OP_PUSH, A);
    issue(OP_PUSH, 4'h0);
    check("badpush_err_o", {31'd0, err_o}, 32'd1);
    check("badpush_err_code", {30'd0, err_code}, 32'd3);
    check("badpush_depth", {30'd0, path_depth}, 32'd1);

    // Response back-pressure: result must hold for 5 stalled cycles.
    rsp_ready = 1'b0;
    set_path(2, A, B, 0);
    v = vecs[0]; v.name = "stall";
    lookup(v);
    collect();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_meta", {14'd0, rsp_meta}, {14'd0, M_N1S0});
      check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", {31'd0, rsp_valid}, 32'd0);

    // Reset in the middle of a scan.
    set_path(0, 0, 0, 0);
    issue(OP_LOOKUP, 4'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_depth", {30'd0, path_depth}, 32'd0);
    check("mid_rst_err_code", {30'd0, err_code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_reset", {31'd0, seen}, 32'd0);

    // Tables were wiped: the {A,B} path no longer finds a node.
    set_path(2, A, B, 0);
    v = vecs[0]; v.name = "post_reset_nonode";
    v.lat = 4; v.hit = 1'b0; v.err = 2'b01; v.idx = 2'd0; v.meta = 18'h0;
    lookup(v);
    collect();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
